// File: rtl/irrigation_ctrl_pkg.sv
// Shared state encoding, request codes and fault codes for the irrigation controller.
package irrigation_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        RUN,
        DONE,
        FAULT
    } state_e;

    localparam logic [1:0] OFF  = 2'b00;
    localparam logic [1:0] VA   = 2'b01;
    localparam logic [1:0] VB   = 2'b10;
    localparam logic [1:0] BOTH = 2'b11;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_LEVEL = 2'b01;
    localparam logic [1:0] ERR_PRESS = 2'b10;
    localparam logic [1:0] ERR_BOTH  = 2'b11;

    function automatic logic [1:0] fault_cause(input logic lvl, input logic prs);
        unique case ({prs, lvl})
            2'b01:   return ERR_LEVEL;
            2'b10:   return ERR_PRESS;
            2'b11:   return ERR_BOTH;
            default: return ERR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/irrigation_ctrl_rr_arbiter.sv
// Round-robin zone search: first requesting zone after 'last', wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] grant,
    output logic                 valid
);
    localparam int unsigned W = $clog2(N);

    always_comb begin
        int unsigned idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        // off runs to N so that 'last' itself is the final candidate
        for (int unsigned off = 1; off <= N; off++) begin
            idx = (32'(last) + off) % N;
            if (!valid && req[idx[W-1:0]]) begin
                grant = idx[W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irrigation_ctrl.sv
// Multi-zone irrigation sequencer: round-robin zone grant, timed valve run, fault latch.
module irrigation_ctrl
    import irrigation_pkg::*;
#(
    parameter int unsigned N_ZONES = 4,
    parameter int unsigned DUR_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2*N_ZONES-1:0]       zone_req,
    input  logic [DUR_W-1:0]           dur,
    input  logic                       level_ok,
    input  logic [1:0]                 press,
    input  logic                       err_clr,
    output logic [2*N_ZONES-1:0]       valve,
    output logic [$clog2(N_ZONES)-1:0] active_zone,
    output logic [N_ZONES-1:0]         zone_done,
    output logic                       busy,
    output logic                       err,
    output logic [1:0]                 err_code
);
    localparam int unsigned ZW = $clog2(N_ZONES);

    state_e               state_q, state_d;
    logic [1:0]           code_q, code_d;
    logic [ZW-1:0]        grant_q, grant_d;
    logic [ZW-1:0]        last_q, last_d;
    logic [DUR_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           errc_q, errc_d;

    logic [2*N_ZONES-1:0] valve_q, valve_d;
    logic [N_ZONES-1:0]   done_q, done_d;
    logic [ZW-1:0]        active_q;
    logic                 busy_q, err_q;

    logic [N_ZONES-1:0]   req_any;
    logic [ZW-1:0]        arb_grant;
    logic                 arb_valid;
    logic [1:0]           arb_code, cur_code;
    logic                 fault_lvl, fault_prs;

    rr_arbiter #(.N(N_ZONES)) u_arb (
        .req   (req_any),
        .last  (last_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        req_any  = '0;
        arb_code = OFF;
        cur_code = OFF;
        for (int unsigned i = 0; i < N_ZONES; i++) begin
            req_any[i] = |zone_req[2*i +: 2];
            if (arb_grant == ZW'(i)) arb_code = zone_req[2*i +: 2];
            if (grant_q == ZW'(i))   cur_code = zone_req[2*i +: 2];
        end
    end

    assign fault_lvl = (state_q == RUN) && !level_ok;
    assign fault_prs = (press != 2'b00);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        errc_d  = errc_q;
        if (fault_lvl || fault_prs) begin
            state_d = FAULT;
            if (state_q != FAULT) errc_d = fault_cause(fault_lvl, fault_prs);
        end else begin
            unique case (state_q)
                IDLE: if (|req_any && level_ok) state_d = SCAN;
                SCAN: begin
                    if (!arb_valid) begin
                        state_d = IDLE;
                    end else begin
                        grant_d = arb_grant;
                        code_d  = arb_code;
                        cnt_d   = dur;
                        state_d = (dur == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cur_code == OFF)            state_d = IDLE;
                    else if (cnt_q == DUR_W'(1))    state_d = DONE;
                end
                DONE: begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
                FAULT: begin
                    if (err_clr && level_ok) begin
                        state_d = IDLE;
                        errc_d  = ERR_NONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so their registers track state_q exactly
        valve_d = '0;
        done_d  = '0;
        for (int unsigned i = 0; i < N_ZONES; i++) begin
            if (grant_d == ZW'(i)) begin
                if (state_d == RUN)  valve_d[2*i +: 2] = code_d;
                if (state_d == DONE) done_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            code_q   <= OFF;
            grant_q  <= '0;
            last_q   <= ZW'(N_ZONES - 1);
            cnt_q    <= '0;
            errc_q   <= ERR_NONE;
            valve_q  <= '0;
            done_q   <= '0;
            active_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            errc_q   <= errc_d;
            valve_q  <= valve_d;
            done_q   <= done_d;
            active_q <= (state_d == RUN || state_d == DONE) ? grant_d : '0;
            busy_q   <= (state_d == SCAN) || (state_d == RUN) || (state_d == DONE);
            err_q    <= (state_d == FAULT);
        end
    end

    assign valve       = valve_q;
    assign zone_done   = done_q;
    assign active_zone = active_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign err_code    = errc_q;

endmodule

// File: tb/tb_irrigation_ctrl.sv
// Scoreboard bench for irrigation_ctrl: stimulus predicts run/fault events, a monitor checks them.
module tb_irrigation_ctrl;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int K_DONE  = 0;
    localparam int K_CUT   = 1;
    localparam int K_FAULT = 2;
    localparam int K_CLEAR = 3;

    typedef struct {
        int             kind;
        int             zone;
        logic [2*N-1:0] pat;
        int             start;
        int             len;
        int             cyc;
        logic [1:0]     ecode;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [2*N-1:0]       zone_req;
    logic [DW-1:0]        dur;
    logic                 level_ok;
    logic [1:0]           press;
    logic                 err_clr;
    logic [2*N-1:0]       valve;
    logic [$clog2(N)-1:0] active_zone;
    logic [N-1:0]         zone_done;
    logic                 busy;
    logic                 err;
    logic [1:0]           err_code;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_m   = N - 1;
    exp_t sbq[$];

    irrigation_ctrl #(.N_ZONES(N), .DUR_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .zone_req    (zone_req),
        .dur         (dur),
        .level_ok    (level_ok),
        .press       (press),
        .err_clr     (err_clr),
        .valve       (valve),
        .active_zone (active_zone),
        .zone_done   (zone_done),
        .busy        (busy),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [1:0] code_of(input logic [2*N-1:0] r, input int z);
        logic [2*N-1:0] s;
        s = r >> (2 * z);
        return s[1:0];
    endfunction

    function automatic int next_zone(input logic [2*N-1:0] r, input int last);
        int z;
        for (int off = 1; off <= N; off++) begin
            z = (last + off) % N;
            if (code_of(r, z) != 2'b00) return z;
        end
        return -1;
    endfunction

    function automatic logic [2*N-1:0] pat_of(input int z, input logic [1:0] code);
        logic [2*N-1:0] p;
        p = '0;
        p[1:0] = code;
        return p << (2 * z);
    endfunction

    function automatic void expect_ev(input int kind, input int zone, input logic [2*N-1:0] pat,
                                      input int start, input int len, input int c, input logic [1:0] ec);
        exp_t e;
        e.kind = kind; e.zone = zone; e.pat = pat; e.start = start;
        e.len = len; e.cyc = c; e.ecode = ec;
        sbq.push_back(e);
    endfunction

    function automatic logic [2*N-1:0] rand_req();
        logic [2*N-1:0] r;
        r = '0;
        while (r == '0) r = (2*N)'($urandom);
        return r;
    endfunction

    // Monitor: a valve run ends either with a zone_done pulse or by being cut; err edges are events too
    initial begin : monitor
        int             run_len;
        int             run_start;
        logic [2*N-1:0] run_pat;
        bit             pat_bad;
        logic           prev_err;
        exp_t           e;
        run_len = 0; run_start = 0; run_pat = '0; pat_bad = 1'b0; prev_err = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                run_len = 0; pat_bad = 1'b0; prev_err = 1'b0;
            end else begin
                if (zone_done != '0 || (valve == '0 && run_len > 0)) begin
                    if (sbq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL sb_unexpected_run_end: zone_done=%b valve=%h, required no event", zone_done, valve);
                    end else begin
                        e = sbq.pop_front();
                        check("ev_kind", (zone_done != '0) ? K_DONE : K_CUT, e.kind);
                        check("ev_cycle", cyc, e.cyc);
                        check("run_len", run_len, e.len);
                        if (e.len > 0) begin
                            check("run_start", run_start, e.start);
                            check("run_pattern", run_pat, e.pat);
                            check("pattern_stable", pat_bad, 0);
                        end
                        if (e.kind == K_DONE) begin
                            check("zone_done", zone_done, 1 << e.zone);
                            check("active_zone_done", active_zone, e.zone);
                            check("busy_done", busy, 1);
                            check("valve_done", valve, 0);
                        end
                    end
                    run_len = 0; pat_bad = 1'b0;
                end
                if (valve != '0) begin
                    if (run_len == 0) begin
                        run_start = cyc; run_pat = valve;
                    end else if (valve != run_pat) begin
                        pat_bad = 1'b1;
                    end
                    run_len++;
                end
                if (err !== prev_err) begin
                    if (sbq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL sb_unexpected_err_edge: err=%b, required no change", err);
                    end else begin
                        e = sbq.pop_front();
                        check("err_kind", err ? K_FAULT : K_CLEAR, e.kind);
                        check("err_cycle", cyc, e.cyc);
                        check("err_code", err_code, e.ecode);
                        if (err) begin
                            check("fault_valve", valve, 0);
                            check("fault_busy", busy, 0);
                        end
                    end
                end
                prev_err = err;
            end
        end
    end

    task automatic run_batch(input logic [2*N-1:0] reqv, input int njobs, input int fixed_dur, input int blk);
        int t, z, d;
        @(negedge clk);
        zone_req = reqv;
        if (blk > 0) begin
            level_ok = 1'b0;
            repeat (blk) @(negedge clk);
        end
        level_ok = 1'b1;
        t = cyc;
        for (int k = 0; k < njobs; k++) begin
            z = next_zone(reqv, last_m);
            d = (fixed_dur >= 0) ? fixed_dur : int'($urandom_range(0, 5));
            expect_ev(K_DONE, z, (d > 0) ? pat_of(z, code_of(reqv, z)) : '0, t + 2, d, t + 2 + d, 2'b00);
            last_m = z;
            @(negedge clk);
            dur = DW'(d);
            // dur is only meaningful in the grant cycle; scramble it elsewhere
            repeat (d + 2) begin
                @(negedge clk);
                dur = DW'($urandom);
            end
            t = t + d + 3;
        end
        zone_req = '0;
    endtask

    task automatic clear_fault();
        @(negedge clk); err_clr = 1'b1; press = 2'b01; level_ok = 1'b1;
        @(negedge clk); press = 2'b00; level_ok = 1'b0;
        @(negedge clk); level_ok = 1'b1;
        expect_ev(K_CLEAR, 0, '0, 0, 0, cyc + 1, 2'b00);
        @(negedge clk); err_clr = 1'b0;
    endtask

    task automatic run_fault(input int z, input logic [1:0] code, input int d, input int when,
                             input logic [1:0] pv, input logic lv);
        int t;
        @(negedge clk);
        zone_req = '0; zone_req[2*z +: 2] = code; t = cyc;
        @(negedge clk);
        dur = DW'(d);
        repeat (when + 1) begin
            @(negedge clk);
            dur = DW'($urandom);
        end
        press = pv; level_ok = lv;
        expect_ev(K_CUT, z, pat_of(z, code), t + 2, when + 1, t + 3 + when, 2'b00);
        expect_ev(K_FAULT, z, '0, 0, 0, t + 3 + when, {pv != 2'b00, !lv});
        @(negedge clk);
        zone_req = '0;
        clear_fault();
    endtask

    task automatic idle_fault();
        @(negedge clk);
        level_ok = 1'b0;
        zone_req = rand_req();
        repeat (3) @(negedge clk);
        zone_req = '0;
        press = 2'b11;
        expect_ev(K_FAULT, 0, '0, 0, 0, cyc + 1, 2'b10);
        clear_fault();
    endtask

    task automatic run_withdraw(input int z, input logic [1:0] code, input int d, input int j);
        int t;
        @(negedge clk);
        zone_req = '0; zone_req[2*z +: 2] = code; t = cyc;
        @(negedge clk);
        dur = DW'(d);
        repeat (j + 1) @(negedge clk);
        zone_req = '0;
        expect_ev(K_CUT, z, pat_of(z, code), t + 2, j + 1, t + 3 + j, 2'b00);
        @(negedge clk);
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        zone_req = '0; zone_req[5:4] = 2'b11;
        @(negedge clk);
        dur = DW'(10);
        repeat (3) @(negedge clk);
        check("pre_reset_valve", valve, 8'h30);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valve", valve, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_active", active_zone, 0);
        zone_req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_m = N - 1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int sel, z, d;
        reset = 1'b1; zone_req = '0; dur = '0; level_ok = 1'b1; press = 2'b00; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valve", valve, 0);
        check("rst_zone_done", zone_done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_active_zone", active_zone, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_batch(8'h33, 3, 2, 0);
        run_batch(8'h04, 1, 3, 0);
        run_batch(8'h40, 1, 0, 0);
        run_fault(1, 2'b01, 4, 1, 2'b10, 1'b1);
        run_withdraw(1, 2'b01, 5, 2);
        run_withdraw(2, 2'b10, 3, 2);
        run_batch(8'h24, 2, -1, 1);
        idle_fault();
        reset_mid_run();
        run_batch(8'hDB, 5, -1, 0);

        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                run_batch(rand_req(), $urandom_range(1, 4), -1, $urandom_range(0, 2));
            end else if (sel < 8) begin
                d = $urandom_range(1, 6);
                z = $urandom_range(0, N - 1);
                case ($urandom_range(1, 3))
                    1:       run_fault(z, 2'($urandom_range(1, 3)), d, $urandom_range(0, d - 1), 2'b00, 1'b0);
                    2:       run_fault(z, 2'($urandom_range(1, 3)), d, $urandom_range(0, d - 1), 2'($urandom_range(1, 3)), 1'b1);
                    default: run_fault(z, 2'($urandom_range(1, 3)), d, $urandom_range(0, d - 1), 2'($urandom_range(1, 3)), 1'b0);
                endcase
            end else if (sel == 8) begin
                d = $urandom_range(1, 6);
                run_withdraw($urandom_range(0, N - 1), 2'($urandom_range(1, 3)), d, $urandom_range(0, d - 1));
            end else begin
                idle_fault();
            end
        end

        repeat (6) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
